// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// life_pkg : shared FSM state type, rule constants and widths for life_engine
// Revision : 1.0
// ============================================================================
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } life_state_e;

  // Conway rules: born with exactly 3, survive with 2 or 3
  localparam logic [8:0] LIFE_B3  = 9'b000001000;
  localparam logic [8:0] LIFE_S23 = 9'b000001100;

  localparam int NCNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/life_row_update.sv
`default_nettype none
// ============================================================================
// life_row_update : combinational next-state of one board row from its
//                   upper/centre/lower rows, with birth and death counts.
// Revision        : 1.0
// ============================================================================
module life_row_update
  import life_pkg::*;
#(
  parameter int COLS = 16,
  parameter int BC_W = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0] i_up,
  input  logic [COLS-1:0] i_centre,
  input  logic [COLS-1:0] i_down,
  input  logic            i_wrap,
  input  logic [8:0]      i_birth_mask,
  input  logic [8:0]      i_survive_mask,
  output logic [COLS-1:0] o_next,
  output logic [BC_W-1:0] o_births,
  output logic [BC_W-1:0] o_deaths
);

  // Rows padded with one neighbour column on each side; bit c+1 is column c
  logic [COLS+1:0]   w_up_ext;
  logic [COLS+1:0]   w_mid_ext;
  logic [COLS+1:0]   w_dn_ext;
  logic [NCNT_W-1:0] w_n;
  logic              w_live;

  assign w_up_ext  = {i_wrap & i_up[0],     i_up,     i_wrap & i_up[COLS-1]};
  assign w_mid_ext = {i_wrap & i_centre[0], i_centre, i_wrap & i_centre[COLS-1]};
  assign w_dn_ext  = {i_wrap & i_down[0],   i_down,   i_wrap & i_down[COLS-1]};

  always_comb begin
    o_next   = '0;
    o_births = '0;
    o_deaths = '0;
    w_n      = '0;
    w_live   = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      w_n = NCNT_W'(w_up_ext[c])  + NCNT_W'(w_up_ext[c+1])  + NCNT_W'(w_up_ext[c+2])
          + NCNT_W'(w_mid_ext[c])                           + NCNT_W'(w_mid_ext[c+2])
          + NCNT_W'(w_dn_ext[c])  + NCNT_W'(w_dn_ext[c+1])  + NCNT_W'(w_dn_ext[c+2]);
      w_live    = i_centre[c] ? i_survive_mask[w_n] : i_birth_mask[w_n];
      o_next[c] = w_live;
      o_births  = o_births + BC_W'(!i_centre[c] && w_live);
      o_deaths  = o_deaths + BC_W'(i_centre[c] && !w_live);
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// life_engine : register-held Game of Life board, one row updated per clock,
//               runtime rules/wrap and saturating birth/death/generation counts.
//               Define LIFE_STABLE_DETECT_EN to add the 'stable' output.
// Revision    : 1.0
// ============================================================================
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 32,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [ROW_W-1:0] load_row_idx,
  input  logic [COLS-1:0]  load_row_data,
  output logic             load_ready,
  input  logic             step_start,
  input  logic             wrap_en,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  output logic             busy,
  output logic             step_done,
  input  logic [ROW_W-1:0] rd_row_idx,
  output logic [COLS-1:0]  rd_row_data,
  output logic [CNT_W-1:0] birth_cnt,
  output logic [CNT_W-1:0] death_cnt,
`ifdef LIFE_STABLE_DETECT_EN
  output logic             stable,
`endif
  output logic [CNT_W-1:0] generation_cnt
);

  localparam int c_bc_w  = $clog2(COLS + 1);
  localparam int c_acc_w = $clog2(ROWS * COLS + 1);
  localparam int c_sum_w = ((CNT_W > c_acc_w) ? CNT_W : c_acc_w) + 1;
  localparam logic [ROW_W-1:0]   c_last_row = ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0]     c_rows_ext = (ROW_W + 1)'(ROWS);
  localparam logic [c_sum_w-1:0] c_sum_max  = c_sum_w'({CNT_W{1'b1}});

  life_state_e        r_state;
  life_state_e        w_state_next;
  logic [COLS-1:0]    r_board [ROWS];
  logic [ROW_W-1:0]   r_row_ptr;
  logic [COLS-1:0]    r_prev_row;
  logic [COLS-1:0]    r_first_row;
  logic [8:0]         r_birth_mask;
  logic [8:0]         r_survive_mask;
  logic               r_wrap;
  logic [c_acc_w-1:0] r_births_acc;
  logic [c_acc_w-1:0] r_deaths_acc;
  logic [CNT_W-1:0]   r_birth_cnt;
  logic [CNT_W-1:0]   r_death_cnt;
  logic [CNT_W-1:0]   r_gen_cnt;
  logic               r_step_done;
  logic [COLS-1:0]    r_rd_data;

  logic               w_idle;
  logic               w_load_acc;
  logic               w_step_acc;
  logic               w_last_row;
  logic               w_rd_idx_ok;
  logic [COLS-1:0]    w_centre;
  logic [COLS-1:0]    w_down;
  logic [COLS-1:0]    w_next_row;
  logic [c_bc_w-1:0]  w_row_births;
  logic [c_bc_w-1:0]  w_row_deaths;
  logic [c_sum_w-1:0] w_birth_sum;
  logic [c_sum_w-1:0] w_death_sum;
  logic [c_sum_w-1:0] w_gen_sum;

  function automatic logic [CNT_W-1:0] sat(input logic [c_sum_w-1:0] v);
    return (v > c_sum_max) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
  endfunction

  assign w_idle      = (r_state == IDLE);
  assign w_load_acc  = w_idle && load_valid && ({1'b0, load_row_idx} < c_rows_ext);
  // A load request in the same cycle takes priority over starting a step
  assign w_step_acc  = w_idle && step_start && !load_valid;
  assign w_last_row  = (r_row_ptr == c_last_row);
  assign w_rd_idx_ok = ({1'b0, rd_row_idx} < c_rows_ext);

  assign w_centre = r_board[r_row_ptr];
  assign w_down   = w_last_row ? (r_wrap ? r_first_row : '0)
                               : r_board[r_row_ptr + ROW_W'(1)];

  life_row_update #(
    .COLS (COLS),
    .BC_W (c_bc_w)
  ) u_row_update (
    .i_up           (r_prev_row),
    .i_centre       (w_centre),
    .i_down         (w_down),
    .i_wrap         (r_wrap),
    .i_birth_mask   (r_birth_mask),
    .i_survive_mask (r_survive_mask),
    .o_next         (w_next_row),
    .o_births       (w_row_births),
    .o_deaths       (w_row_deaths)
  );

  assign w_birth_sum = c_sum_w'(r_birth_cnt) + c_sum_w'(r_births_acc);
  assign w_death_sum = c_sum_w'(r_death_cnt) + c_sum_w'(r_deaths_acc);
  assign w_gen_sum   = c_sum_w'(r_gen_cnt) + c_sum_w'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_step_acc) w_state_next = STEP;
      STEP:    if (w_last_row) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) r_board[r] <= '0;
    end else if (w_load_acc) begin
      r_board[load_row_idx] <= load_row_data;
    end else if (r_state == STEP) begin
      r_board[r_row_ptr] <= w_next_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_ptr      <= '0;
      r_prev_row     <= '0;
      r_first_row    <= '0;
      r_birth_mask   <= '0;
      r_survive_mask <= '0;
      r_wrap         <= 1'b0;
      r_births_acc   <= '0;
      r_deaths_acc   <= '0;
      r_birth_cnt    <= '0;
      r_death_cnt    <= '0;
      r_gen_cnt      <= '0;
      r_step_done    <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      if (w_step_acc) begin
        r_birth_mask   <= birth_mask;
        r_survive_mask <= survive_mask;
        r_wrap         <= wrap_en;
        r_prev_row     <= wrap_en ? r_board[ROWS-1] : '0;
        r_first_row    <= r_board[0];
        r_row_ptr      <= '0;
        r_births_acc   <= '0;
        r_deaths_acc   <= '0;
      end else if (r_state == STEP) begin
        // The old centre row becomes the upper neighbour of the next row
        r_prev_row   <= w_centre;
        r_row_ptr    <= r_row_ptr + ROW_W'(1);
        r_births_acc <= r_births_acc + c_acc_w'(w_row_births);
        r_deaths_acc <= r_deaths_acc + c_acc_w'(w_row_deaths);
      end else if (r_state == DONE) begin
        r_step_done <= 1'b1;
        r_birth_cnt <= sat(w_birth_sum);
        r_death_cnt <= sat(w_death_sum);
        r_gen_cnt   <= sat(w_gen_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)              r_rd_data <= '0;
    else if (w_rd_idx_ok) r_rd_data <= r_board[rd_row_idx];
    else                  r_rd_data <= '0;
  end

`ifdef LIFE_STABLE_DETECT_EN
  logic r_stable;

  always_ff @(posedge clk) begin
    if (rst)                   r_stable <= 1'b0;
    else if (w_load_acc)       r_stable <= 1'b0;
    else if (r_state == DONE)  r_stable <= (r_births_acc == '0) && (r_deaths_acc == '0);
  end

  assign stable = r_stable;
`endif

  assign load_ready     = w_idle;
  assign busy           = !w_idle;
  assign step_done      = r_step_done;
  assign rd_row_data    = r_rd_data;
  assign birth_cnt      = r_birth_cnt;
  assign death_cnt      = r_death_cnt;
  assign generation_cnt = r_gen_cnt;

endmodule
`default_nettype wire

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game of Life engine with an ROWS x COLS board held in registers.
- Computes one generation row-serially (one row per clock) rather than as a single combinational update of the whole board.
- Birth/survive rules and edge wrap are runtime-configurable. Maintains saturating birth, death and generation counters.
- Sits between the board loader/host interface and the display scan logic.

Parameters:
- ROWS, 16, board height (>=3)
- COLS, 16, board width (>=3)
- CNT_W, 32, width of the birth/death/generation counters
- ROW_W, $clog2(ROWS), row index width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load_valid  in  1  write a row into the board
- load_row_idx  in  ROW_W  row being written
- load_row_data  in  COLS  row contents; bit c = column c
- load_ready  out  1  engine accepts loads (IDLE)
- step_start  in  1  request one generation
- wrap_en  in  1  1 = toroidal edges; 0 = cells outside the board are dead
- birth_mask  in  9  bit n set = dead cell with n neighbours is born
- survive_mask  in  9  bit n set = live cell with n neighbours survives
- busy  out  1  generation in progress
- step_done  out  1  one-cycle pulse when a generation completes
- rd_row_idx  in  ROW_W  read row select
- rd_row_data  out  COLS  board row, registered, 1-cycle latency
- birth_cnt  out  CNT_W  cumulative births
- death_cnt  out  CNT_W  cumulative deaths
- generation_cnt  out  CNT_W  completed generations

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: board all 0; all counters 0; busy=0; step_done=0; rd_row_data=0; state IDLE.
- FSM states and transitions:
  - IDLE -> STEP on step_start.
  - STEP stays in STEP while row_ptr < ROWS-1.
  - STEP -> DONE after row ROWS-1 is written.
  - DONE -> IDLE unconditionally.
- load_ready = (state==IDLE).
  - In IDLE, load_valid writes load_row_data to board[load_row_idx] at the clock edge.
  - load_valid outside IDLE is ignored.
  - load_row_idx >= ROWS is ignored.
- load_valid and step_start in the same IDLE cycle: the load is performed and step_start is ignored.
- step_start accepted at edge T:
  - Latch birth_mask, survive_mask and wrap_en into shadow registers.
  - Latch prev_row = board[ROWS-1] if wrap is enabled, else 0.
  - Latch first_row = board[0].
  - Set row_ptr = 0 and busy = 1.
  - Mask, wrap and step_start changes are ignored while busy.
- STEP cycle for row r:
  - Upper neighbour row = prev_row.
  - Centre row = board[r].
  - Lower neighbour row = board[r+1]; for r = ROWS-1 it is first_row if wrap is enabled, else 0.
  - Column wrap follows the latched wrap_en the same way.
  - New row written to board[r]; prev_row <= old board[r]; row_ptr increments.
  - Rows 0..ROWS-1 are written at edges T+1..T+ROWS.
- Per-cell rule: n = live neighbour count, 0..8.
  - Dead cell becomes live iff birth_mask[n].
  - Live cell stays live iff survive_mask[n].
- Per-row birth/death counts (width $clog2(COLS+1)) accumulate into generation accumulators cleared at step_start.
- DONE (edge T+ROWS+1):
  - step_done=1 for exactly one cycle; busy=0.
  - birth_cnt += births, death_cnt += deaths, generation_cnt += 1.
  - All three counters saturate at 2^CNT_W-1 and never wrap.
- rd_row_data <= board[rd_row_idx] every cycle, including during STEP, so mid-step reads may return a mixed generation. rd_row_idx >= ROWS returns 0.
- rst mid-step: abort the step, clear the board and counters, return to IDLE with no step_done pulse.

Optional Feature:
- Macro: LIFE_STABLE_DETECT_EN.
- Defined: adds output port stable (1 bit, reset 0).
  - stable <= 1 at DONE when the generation had zero births and zero deaths; otherwise <= 0 at DONE.
  - Any accepted load clears stable.
- Undefined: no stable port and no extra logic.

Decomposition:
- life_pkg holds:
  - FSM state enum (IDLE, STEP, DONE).
  - Rule constants LIFE_B3 = 9'b000001000 and LIFE_S23 = 9'b000001100.
  - Neighbour-count width constant (4 bits).
- Sub-module life_row_update: purely combinational. Inputs: up/centre/down rows, wrap, masks. Outputs: next row, row birth count, row death count. Instantiated once.

Test Plan:
- Blinker, B3/S23, wrap=1: live (5,4),(5,5),(5,6); step_start at T -> step_done at T+17; live (4,5),(5,5),(6,5); birth_cnt=2, death_cnt=2, generation_cnt=1.
- Wrap vs no-wrap: horizontal blinker on row 0 cols 0..2, step -> wrap=1 gives (15,1),(0,1),(1,1); wrap=0 gives (0,1),(1,1) only, birth_cnt=1, death_cnt=2.
- Custom rule B36/S23 (birth_mask=9'h048): 2x2 block plus cell (3,3), 3 neighbours of (2,2) -> births follow mask; HighLife replicator counts match golden model.
- Saturation with CNT_W=4: 20 blinker steps -> generation_cnt=15, birth_cnt=15, death_cnt=15.
- Rule/load during busy: change birth_mask and pulse load_valid at T+5 -> board result identical to the undisturbed run; load_ready=0 during T+1..T+17.
- rst at T+8 mid-step -> board all 0, counters 0, busy=0, no step_done; with LIFE_STABLE_DETECT_EN, a 2x2 block step gives stable=1.
